otter_intr_ctrl: RTL and testbench



---
 rtl/otter_intc_pkg.sv | 41 ++++
 rtl/otter_intc_edge_sync.sv | 53 +++++
 rtl/otter_intr_ctrl.sv | 135 +++++++++++++
 tb/tb_otter_intr_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_intc_pkg.sv
// otter_intc_pkg -- shared constants, types and helpers for the OTTER
// multi-source interrupt controller (otter_intr_ctrl).
// Build option: OTTER_INTC_SYNC_EN (see otter_intc_edge_sync).
package otter_intc_pkg;

   // Largest number of sources the register map can describe
   localparam int INTC_MAX_SRC = 32;

   // Register offsets from the block base address
   localparam logic [31:0] INTC_ENABLE_OFS  = 32'h0000_0000;
   localparam logic [31:0] INTC_PENDING_OFS = 32'h0000_0004;
   localparam logic [31:0] INTC_CAUSE_OFS   = 32'h0000_0008;
   localparam logic [31:0] INTC_EOI_OFS     = 32'h0000_000C;

   // Controller state: waiting for a claim, or inside a handler until EOI
   typedef enum logic {
      INTC_IDLE    = 1'b0,
      INTC_SERVICE = 1'b1
   } intc_state_t;

   // Ones in the bit positions that correspond to implemented sources
   function automatic logic [31:0] intc_src_mask(input int n);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < INTC_MAX_SRC; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Index of the lowest set bit (fixed priority: source 0 wins); 0 if none
   function automatic logic [4:0] intc_lowest_idx(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = INTC_MAX_SRC - 1; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/otter_intc_edge_sync.sv
// otter_intc_edge_sync -- per-source rising-edge detector for otter_intr_ctrl.
// With OTTER_INTC_SYNC_EN defined the source first passes a 2-flop
// synchronizer; otherwise it is assumed synchronous to clk.
// A short arming chain suppresses the false edge a source held high
// through reset release would otherwise produce.
module otter_intc_edge_sync
   import otter_intc_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_src,
   output logic o_rise
);

`ifdef OTTER_INTC_SYNC_EN
   // Arm only once the synchronizer and previous-value flop hold real samples
   localparam int ARM_W = 3;

   logic [1:0] r_sync;
   logic       w_src;

   // Two-flop synchronizer for an asynchronous source
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[0], i_src};
   end

   assign w_src = r_sync[1];
`else
   localparam int ARM_W = 1;

   logic w_src;

   assign w_src = i_src;
`endif

   logic             r_prev;
   logic [ARM_W-1:0] r_arm;

   // Previous-value flop and post-reset arming chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 1'b0;
         r_arm  <= '0;
      end else begin
         r_prev <= w_src;
         r_arm  <= (r_arm << 1) | ARM_W'(1);
      end
   end

   assign o_rise = w_src & ~r_prev & r_arm[ARM_W-1];

endmodule

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl -- multi-source interrupt controller feeding the OTTER
// MCU INTR input. Latches source edges as pending, masks with ENABLE,
// raises one level request, claims the lowest enabled pending source on
// INT_TAKEN and blocks further requests until software writes EOI.
// Build option: OTTER_INTC_SYNC_EN adds a 2-flop input synchronizer.
module otter_intr_ctrl
   import otter_intc_pkg::*;
#(
   parameter int          NUM_SRC   = 8,
   parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               int_taken,
   input  logic [31:0]        iobus_addr,
   input  logic [31:0]        iobus_wdata,
   input  logic               iobus_wr,
   output logic [31:0]        iobus_rdata,
   output logic               intr
);

   localparam logic [31:0] SRC_MASK = intc_src_mask(NUM_SRC);

   // Registers are kept 32 bits wide; bits above NUM_SRC-1 are held at 0
   logic [31:0] r_enable;
   logic [31:0] r_pending;
   logic        r_cause_vld;
   logic [4:0]  r_cause_id;
   intc_state_t r_state;
   logic        r_intr;

   logic [31:0] w_rise;
   logic        w_hit_en;
   logic        w_hit_pend;
   logic        w_hit_cause;
   logic        w_hit_eoi;
   logic        w_wr_en;
   logic [31:0] w_w1c;
   logic        w_eoi;
   logic [31:0] w_active;
   logic        w_req;
   logic [4:0]  w_claim_id;
   logic        w_claim;
   logic [31:0] w_claim_mask;

   // One edge detector per implemented source; unused positions never rise
   for (genvar gi = 0; gi < INTC_MAX_SRC; gi++) begin : g_src
      if (gi < NUM_SRC) begin : g_on
         otter_intc_edge_sync u_edge (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_src  (irq_src[gi]),
            .o_rise (w_rise[gi])
         );
      end else begin : g_off
         assign w_rise[gi] = 1'b0;
      end
   end

   // Full 32-bit address decode of the four-register block
   assign w_hit_en    = (iobus_addr == BASE_ADDR + INTC_ENABLE_OFS);
   assign w_hit_pend  = (iobus_addr == BASE_ADDR + INTC_PENDING_OFS);
   assign w_hit_cause = (iobus_addr == BASE_ADDR + INTC_CAUSE_OFS);
   assign w_hit_eoi   = (iobus_addr == BASE_ADDR + INTC_EOI_OFS);

   assign w_wr_en = iobus_wr & w_hit_en;
   assign w_w1c   = (iobus_wr & w_hit_pend) ? (iobus_wdata & SRC_MASK) : '0;
   // EOI only matters while a handler is active
   assign w_eoi   = iobus_wr & w_hit_eoi & (r_state == INTC_SERVICE);

   // Priority select over enabled pending sources
   assign w_active   = r_pending & r_enable;
   assign w_req      = |w_active;
   assign w_claim_id = intc_lowest_idx(w_active);
   // A take is honoured only if a request is still live; a request masked
   // in the same cycle is dropped silently
   assign w_claim      = int_taken & r_intr & w_req & (r_state == INTC_IDLE);
   assign w_claim_mask = w_claim ? (32'd1 << w_claim_id) : '0;

   // ENABLE register, software writable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_enable <= '0;
      else if (w_wr_en) r_enable <= iobus_wdata & SRC_MASK;
   end

   // PENDING: clears from W1C and claim, new edges take precedence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= '0;
      else        r_pending <= (r_pending & ~w_w1c & ~w_claim_mask) | w_rise;
   end

   // Service FSM and CAUSE register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= INTC_IDLE;
         r_cause_vld <= 1'b0;
         r_cause_id  <= '0;
      end else begin
         case (r_state)
            INTC_IDLE: begin
               if (w_claim) begin
                  r_state     <= INTC_SERVICE;
                  r_cause_vld <= 1'b1;
                  r_cause_id  <= w_claim_id;
               end
            end
            INTC_SERVICE: begin
               if (w_eoi) begin
                  r_state     <= INTC_IDLE;
                  r_cause_vld <= 1'b0;
               end
            end
            default: r_state <= INTC_IDLE;
         endcase
      end
   end

   // Registered request: only from IDLE, dropped in the claim cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_intr <= 1'b0;
      else        r_intr <= (r_state == INTC_IDLE) & w_req & ~w_claim;
   end

   assign intr = r_intr;

   // Zero-wait read mux; misses and EOI read as 0
   always_comb begin
      iobus_rdata = '0;
      if (w_hit_en)         iobus_rdata = r_enable;
      else if (w_hit_pend)  iobus_rdata = r_pending;
      else if (w_hit_cause) iobus_rdata = {r_cause_vld, 26'd0, r_cause_id};
   end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl -- self-checking bench for otter_intr_ctrl.
// Expected values are queued when stimulus is applied and compared when
// the matching DUT output is sampled. Latency adapts to OTTER_INTC_SYNC_EN.
module tb_otter_intr_ctrl;

   localparam int          NUM_SRC = 8;
   localparam logic [31:0] BASE    = 32'h1100_0100;
`ifdef OTTER_INTC_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   localparam logic [31:0] OFS_EN    = 32'h0;
   localparam logic [31:0] OFS_PEND  = 32'h4;
   localparam logic [31:0] OFS_CAUSE = 32'h8;
   localparam logic [31:0] OFS_EOI   = 32'hC;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_SRC-1:0] irq_src = '0;
   logic               int_taken = 1'b0;
   logic [31:0]        iobus_addr = '0;
   logic [31:0]        iobus_wdata = '0;
   logic               iobus_wr = 1'b0;
   logic [31:0]        iobus_rdata;
   logic               intr;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   otter_intr_ctrl #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_src     (irq_src),
      .int_taken   (int_taken),
      .iobus_addr  (iobus_addr),
      .iobus_wdata (iobus_wdata),
      .iobus_wr    (iobus_wr),
      .iobus_rdata (iobus_rdata),
      .intr        (intr)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: obs=0x%08h exp=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         it = sb_q.pop_front();
         chk(it.tag, obs, it.exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic io_wr(input logic [31:0] ofs, input logic [31:0] data);
      iobus_addr  = BASE + ofs;
      iobus_wdata = data;
      iobus_wr    = 1'b1;
      @(negedge clk);
      iobus_wr    = 1'b0;
   endtask

   // Read a register (masked) and compare against a queued expectation
   task automatic exp_reg(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp, input logic [31:0] mask = 32'hFFFF_FFFF);
      sb_push(tag, exp);
      iobus_wr   = 1'b0;
      iobus_addr = addr;
      #1;
      sb_check(iobus_rdata & mask);
   endtask

   task automatic exp_intr(input string tag, input logic exp);
      sb_push(tag, {31'd0, exp});
      sb_check({31'd0, intr});
   endtask

   // One-clock pulse on the given sources; returns just after edge k
   task automatic pulse_src(input logic [NUM_SRC-1:0] bits);
      irq_src = irq_src | bits;
      @(negedge clk);
      irq_src = irq_src & ~bits;
   endtask

   task automatic take();
      int_taken = 1'b1;
      @(negedge clk);
      int_taken = 1'b0;
   endtask

   initial begin
      // Reset state
      step(2);
      exp_reg("rst_en",    BASE + OFS_EN,    32'h0);
      exp_reg("rst_pend",  BASE + OFS_PEND,  32'h0);
      exp_reg("rst_cause", BASE + OFS_CAUSE, 32'h0);
      exp_intr("rst_intr", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(4);
      exp_reg("eoi_reads0", BASE + OFS_EOI, 32'h0);
      exp_reg("miss_rd",    BASE + 32'h10,  32'h0);
      exp_reg("unalign_rd", BASE + 32'h1,   32'h0);
      take();
      exp_reg("idle_take_nop", BASE + OFS_CAUSE, 32'h0);

      // Single source, claim
      io_wr(OFS_EN, 32'h05);
      exp_reg("en_rd", BASE + OFS_EN, 32'h05);
      pulse_src(8'h04);
      step(L);
      exp_reg("p2_pend", BASE + OFS_PEND, 32'h04);
      exp_intr("p2_intr_early", 1'b0);
      step(1);
      exp_intr("p2_intr", 1'b1);
      take();
      exp_reg("p2_cause", BASE + OFS_CAUSE, 32'h8000_0002);
      exp_reg("p2_pend_clr", BASE + OFS_PEND, 32'h0);
      exp_intr("p2_intr_svc", 1'b0);
      io_wr(OFS_EOI, 32'h0);
      exp_reg("p2_eoi_vld", BASE + OFS_CAUSE, 32'h0, 32'h8000_0000);

      // Simultaneous edges, fixed priority
      io_wr(OFS_EN, 32'hFFFF_FFFF);
      exp_reg("en_upper0", BASE + OFS_EN, 32'hFF);
      pulse_src(8'h22);
      step(L + 1);
      exp_intr("pr_intr", 1'b1);
      take();
      exp_reg("pr_cause1", BASE + OFS_CAUSE, 32'h8000_0001);
      exp_reg("pr_pend", BASE + OFS_PEND, 32'h20);
      take();
      exp_reg("svc_take_nop", BASE + OFS_CAUSE, 32'h8000_0001);
      exp_reg("svc_take_pend", BASE + OFS_PEND, 32'h20);
      io_wr(OFS_EOI, 32'hDEAD_BEEF);
      exp_intr("pr_eoi_intr0", 1'b0);
      step(1);
      exp_intr("pr_reassert", 1'b1);
      take();
      exp_reg("pr_cause5", BASE + OFS_CAUSE, 32'h8000_0005);

      // Edge during service
      pulse_src(8'h08);
      step(L);
      exp_reg("svc_pend3", BASE + OFS_PEND, 32'h08);
      step(2);
      exp_intr("svc_intr0", 1'b0);
      io_wr(OFS_EOI, 32'h0);
      exp_intr("svc_eoi_n", 1'b0);
      step(1);
      exp_intr("svc_eoi_n1", 1'b1);
      take();
      exp_reg("svc_cause3", BASE + OFS_CAUSE, 32'h8000_0003);
      io_wr(OFS_EOI, 32'h0);
      io_wr(OFS_EOI, 32'h0);
      step(2);
      exp_intr("idle_eoi_intr", 1'b0);
      exp_reg("idle_eoi_vld", BASE + OFS_CAUSE, 32'h0, 32'h8000_0000);

      // W1C colliding with a new edge on the same bit
      pulse_src(8'h10);
      step(L);
      exp_reg("col_pre", BASE + OFS_PEND, 32'h10);
      step(2);
      irq_src[4] = 1'b1;
      repeat (L) begin
         @(negedge clk);
         irq_src[4] = 1'b0;
      end
      iobus_addr  = BASE + OFS_PEND;
      iobus_wdata = 32'h10;
      iobus_wr    = 1'b1;
      @(negedge clk);
      iobus_wr    = 1'b0;
      irq_src[4]  = 1'b0;
      exp_reg("col_setwins", BASE + OFS_PEND, 32'h10);
      io_wr(OFS_PEND, 32'h10);
      exp_reg("w1c_clr", BASE + OFS_PEND, 32'h0);

      // Masked source, then enable
      io_wr(OFS_EN, 32'h0);
      step(2);
      pulse_src(8'h01);
      step(L);
      exp_reg("msk_pend", BASE + OFS_PEND, 32'h01);
      step(2);
      exp_intr("msk_intr0", 1'b0);
      io_wr(OFS_EN, 32'h01);
      exp_intr("en_edge_intr0", 1'b0);
      step(1);
      exp_intr("en_intr1", 1'b1);
      take();
      exp_reg("en_cause0", BASE + OFS_CAUSE, 32'h8000_0000);
      pulse_src(8'h04);
      step(L);
      exp_reg("rs_pre_pend", BASE + OFS_PEND, 32'h04);

      // Asynchronous reset mid-service, source held high across release
      #2;
      rst_n = 1'b0;
      #1;
      exp_intr("ar_intr", 1'b0);
      exp_reg("ar_en",    BASE + OFS_EN,    32'h0);
      exp_reg("ar_pend",  BASE + OFS_PEND,  32'h0);
      exp_reg("ar_cause", BASE + OFS_CAUSE, 32'h0);
      irq_src[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step(6);
      exp_reg("ar_hold_nopend", BASE + OFS_PEND, 32'h0);
      irq_src[0] = 1'b0;
      step(2);
      pulse_src(8'h01);
      step(L);
      exp_reg("ar_fresh_edge", BASE + OFS_PEND, 32'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
